nh_lcd_bus_arbiter: RTL and testbench
=====================================

NH_LCD_BUS_ARBITER -- requirements
Module: nh_lcd_bus_arbiter

Interface
REQ-001 Parameter TURNAROUND_CYCLES, default 2: idle cycles inserted between releasing one owner and granting the next; legal range 1-15.
REQ-002 clk  input  1  system clock; all logic is on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_enable  input  1  when low, no new grants are issued; a current owner keeps the bus until it releases.
REQ-005 i_timeout  input  32  maximum cycles an owner may hold the bus; 0 disables the timeout.
REQ-006 i_clear_status  input  1  pulse that clears o_timeout_flag.
REQ-007 i_cmd_req / o_cmd_gnt / i_cmd_release  in/out/in  1 each  command requester request level, grant level and release pulse.
REQ-008 i_pix_req / o_pix_gnt / i_pix_release  in/out/in  1 each  pixel-writer request level, grant level and release pulse.
REQ-009 i_cmd_cmd_mode, i_cmd_write, i_cmd_read, i_cmd_data_out_en  input  1 each  command requester bus controls.
REQ-010 i_cmd_data_out  input  8  command requester data byte.
REQ-011 i_pix_cmd_mode, i_pix_write, i_pix_read, i_pix_data_out_en  input  1 each  pixel requester bus controls.
REQ-012 i_pix_data_out  input  8  pixel requester data byte.
REQ-013 o_cmd_mode, o_write, o_read, o_data_out_en  output  1 each  muxed physical bus controls.
REQ-014 o_data_out  output  8  muxed physical data byte.
REQ-015 o_owner  output  2  current owner: 0 none, 1 cmd, 2 pix.
REQ-016 o_timeout_flag  output  1  sticky flag, set when an owner is force-released.

Function
REQ-017 The FSM SHALL have the states IDLE, OWN_CMD, OWN_PIX and TURNAROUND.
REQ-018 In IDLE with i_enable high, the FSM SHALL grant the single requester when only one requests.
REQ-019 In IDLE with both requesting, the FSM SHALL grant the requester that did not own last (round-robin); after reset the command requester wins the first tie.
REQ-020 Grant latency SHALL be 1 cycle: request sampled in IDLE -> o_*_gnt and o_owner valid on the next cycle.
REQ-021 While a requester owns the bus, its grant SHALL stay high until the cycle after it samples its release pulse or the timeout fires; a request drop without a release SHALL NOT end ownership.
REQ-022 A release pulse from the non-owner SHALL be ignored.
REQ-023 On release the FSM SHALL deassert the grant, set o_owner=0 and enter TURNAROUND for exactly TURNAROUND_CYCLES cycles, then return to IDLE.
REQ-024 Bus outputs SHALL be registered, 1-cycle latency from the owner's inputs, and SHALL equal the owner's inputs delayed one cycle.
REQ-025 With no owner (IDLE/TURNAROUND), the bus outputs SHALL be idle: o_cmd_mode=1, o_write=0, o_read=0, o_data_out_en=1, o_data_out=0x00.
REQ-026 Hold counter: 32-bit, cleared at each grant, incremented each owned cycle; when i_timeout!=0 and the count reaches i_timeout, the FSM SHALL force-release as in REQ-023 and set o_timeout_flag.
REQ-027 A release and a timeout in the same cycle SHALL be treated as a normal release; o_timeout_flag SHALL NOT be set.
REQ-028 i_clear_status together with a new timeout event in the same cycle SHALL leave o_timeout_flag set (set wins).
REQ-029 When i_enable goes low mid-ownership, the owner SHALL keep the bus until release or timeout; after that the FSM SHALL stay in IDLE until i_enable returns high.
REQ-030 A request arriving during TURNAROUND SHALL be held pending and arbitrated in the following IDLE cycle.
REQ-031 At most one grant SHALL be high in any cycle.

Reset
REQ-032 While rst is high, the FSM SHALL enter IDLE, both grants SHALL be 0, o_owner SHALL be 0 and the bus outputs SHALL take their idle values.
REQ-033 Reset SHALL also clear the hold counter, o_timeout_flag and the turnaround counter, and set the round-robin pointer to cmd.
REQ-034 Reset asserted mid-ownership SHALL drop the grant on the next edge with no turnaround.

Verification
REQ-035 Single cmd request, hold 5 cycles, release -> o_cmd_gnt high 1 cycle after request; o_data_out tracks i_cmd_data_out with 1-cycle delay; idle bus for 2 cycles; back in IDLE.
REQ-036 cmd and pix request together after reset -> cmd granted first; after cmd release plus 2 turnaround cycles -> pix granted; on the next tie -> cmd granted.
REQ-037 i_timeout=10, pix never releases -> grant drops after 10 owned cycles, o_timeout_flag=1; i_clear_status -> 0.
REQ-038 Release and timeout in the same cycle -> o_timeout_flag remains 0.
REQ-039 rst asserted during pix ownership with i_pix_write=1 -> next cycle o_pix_gnt=0, o_write=0, o_cmd_mode=1, o_owner=0.
REQ-040 i_enable low with both requesting -> no grant for 20 cycles; i_enable high -> grant on the next cycle.

Source files
------------

// File: rtl/nh_lcd_bus_arbiter.sv
// nh_lcd_bus_arbiter
//   Arbitrates the physical LCD bus between a command requester (cmd) and a
//   pixel writer (pix). Ownership is granted from IDLE with a 1-cycle
//   latency. Ties are broken round-robin, and cmd wins the first tie after
//   reset. An owner keeps the bus until it pulses its release or until its
//   hold time reaches i_timeout. After ownership ends, the bus sits idle for
//   TURNAROUND_CYCLES before the next arbitration. Bus outputs are the
//   owner's controls registered once, or the idle pattern when nobody owns
//   the bus.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_enable                 allow new grants
//   i_timeout[31:0]          max owned cycles, 0 = no limit
//   i_clear_status           clears o_timeout_flag
//   i_{cmd,pix}_req/release  request level / release pulse per requester
//   o_{cmd,pix}_gnt          grant level per requester
//   i_{cmd,pix}_*            per-requester bus controls and data
//   o_cmd_mode, o_write, o_read, o_data_out_en, o_data_out  muxed bus
//   o_owner[1:0]             0 none, 1 cmd, 2 pix
//   o_timeout_flag           sticky force-release indication
module nh_lcd_bus_arbiter #(
    parameter int TURNAROUND_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic [31:0] i_timeout,
    input  logic        i_clear_status,
    input  logic        i_cmd_req,
    output logic        o_cmd_gnt,
    input  logic        i_cmd_release,
    input  logic        i_pix_req,
    output logic        o_pix_gnt,
    input  logic        i_pix_release,
    input  logic        i_cmd_cmd_mode,
    input  logic        i_cmd_write,
    input  logic        i_cmd_read,
    input  logic        i_cmd_data_out_en,
    input  logic [7:0]  i_cmd_data_out,
    input  logic        i_pix_cmd_mode,
    input  logic        i_pix_write,
    input  logic        i_pix_read,
    input  logic        i_pix_data_out_en,
    input  logic [7:0]  i_pix_data_out,
    output logic        o_cmd_mode,
    output logic        o_write,
    output logic        o_read,
    output logic        o_data_out_en,
    output logic [7:0]  o_data_out,
    output logic [1:0]  o_owner,
    output logic        o_timeout_flag
);

    typedef enum logic [1:0] {IDLE, OWN_CMD, OWN_PIX, TURNAROUND} state_t;

    localparam logic [3:0] TA_LOAD = 4'(TURNAROUND_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [3:0]  ta_q, ta_d;
    logic        rr_cmd_q, rr_cmd_d;     // 1: cmd wins the next tie
    logic        flag_q, flag_d;
    logic        cmd_gnt_q, cmd_gnt_d;
    logic        pix_gnt_q, pix_gnt_d;
    logic [1:0]  owner_q, owner_d;
    logic        cmd_mode_q, cmd_mode_d;
    logic        write_q, write_d;
    logic        read_q, read_d;
    logic        data_out_en_q, data_out_en_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        timeout_hit;
    logic        set_flag;

    // The current cycle is counted as owned, so the bus is held for
    // exactly i_timeout cycles.
    assign timeout_hit = (i_timeout != 32'd0) &&
                         (({1'b0, hold_q} + 33'd1) >= {1'b0, i_timeout});

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        ta_d          = ta_q;
        rr_cmd_d      = rr_cmd_q;
        set_flag      = 1'b0;
        cmd_mode_d    = 1'b1;
        write_d       = 1'b0;
        read_d        = 1'b0;
        data_out_en_d = 1'b1;
        data_out_d    = 8'h00;

        case (state_q)
            IDLE: begin
                if (i_enable) begin
                    if (i_cmd_req && (!i_pix_req || rr_cmd_q)) begin
                        state_d  = OWN_CMD;
                        hold_d   = 32'd0;
                        rr_cmd_d = 1'b0;
                    end else if (i_pix_req) begin
                        state_d  = OWN_PIX;
                        hold_d   = 32'd0;
                        rr_cmd_d = 1'b1;
                    end
                end
            end
            OWN_CMD: begin
                cmd_mode_d    = i_cmd_cmd_mode;
                write_d       = i_cmd_write;
                read_d        = i_cmd_read;
                data_out_en_d = i_cmd_data_out_en;
                data_out_d    = i_cmd_data_out;
                if (i_cmd_release || timeout_hit) begin
                    state_d  = TURNAROUND;
                    ta_d     = TA_LOAD;
                    set_flag = !i_cmd_release;  // a release wins over a timeout
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
            OWN_PIX: begin
                cmd_mode_d    = i_pix_cmd_mode;
                write_d       = i_pix_write;
                read_d        = i_pix_read;
                data_out_en_d = i_pix_data_out_en;
                data_out_d    = i_pix_data_out;
                if (i_pix_release || timeout_hit) begin
                    state_d  = TURNAROUND;
                    ta_d     = TA_LOAD;
                    set_flag = !i_pix_release;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
            default: begin  // TURNAROUND
                if (ta_q == 4'd0) state_d = IDLE;
                else              ta_d    = ta_q - 4'd1;
            end
        endcase

        cmd_gnt_d = (state_d == OWN_CMD);
        pix_gnt_d = (state_d == OWN_PIX);
        owner_d   = (state_d == OWN_CMD) ? 2'd1 :
                    (state_d == OWN_PIX) ? 2'd2 : 2'd0;
        // A new timeout event takes priority over a clear in the same cycle.
        flag_d    = set_flag ? 1'b1 : (i_clear_status ? 1'b0 : flag_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            hold_q        <= 32'd0;
            ta_q          <= 4'd0;
            rr_cmd_q      <= 1'b1;
            flag_q        <= 1'b0;
            cmd_gnt_q     <= 1'b0;
            pix_gnt_q     <= 1'b0;
            owner_q       <= 2'd0;
            cmd_mode_q    <= 1'b1;
            write_q       <= 1'b0;
            read_q        <= 1'b0;
            data_out_en_q <= 1'b1;
            data_out_q    <= 8'h00;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            ta_q          <= ta_d;
            rr_cmd_q      <= rr_cmd_d;
            flag_q        <= flag_d;
            cmd_gnt_q     <= cmd_gnt_d;
            pix_gnt_q     <= pix_gnt_d;
            owner_q       <= owner_d;
            cmd_mode_q    <= cmd_mode_d;
            write_q       <= write_d;
            read_q        <= read_d;
            data_out_en_q <= data_out_en_d;
            data_out_q    <= data_out_d;
        end
    end

    assign o_cmd_gnt      = cmd_gnt_q;
    assign o_pix_gnt      = pix_gnt_q;
    assign o_owner        = owner_q;
    assign o_timeout_flag = flag_q;
    assign o_cmd_mode     = cmd_mode_q;
    assign o_write        = write_q;
    assign o_read         = read_q;
    assign o_data_out_en  = data_out_en_q;
    assign o_data_out     = data_out_q;

endmodule

// File: tb/tb_nh_lcd_bus_arbiter.sv
// Scoreboard bench for nh_lcd_bus_arbiter. Each negedge the driver picks
// random inputs, advances a cycle-level reference model and queues the
// outputs expected after the next rising edge. A monitor compares them
// shortly after that edge.
module tb_nh_lcd_bus_arbiter;

    localparam int TA = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable, i_clear_status;
    logic [31:0] i_timeout;
    logic        i_cmd_req, i_cmd_release, i_pix_req, i_pix_release;
    logic        i_cmd_cmd_mode, i_cmd_write, i_cmd_read, i_cmd_data_out_en;
    logic [7:0]  i_cmd_data_out;
    logic        i_pix_cmd_mode, i_pix_write, i_pix_read, i_pix_data_out_en;
    logic [7:0]  i_pix_data_out;
    logic        o_cmd_gnt, o_pix_gnt;
    logic        o_cmd_mode, o_write, o_read, o_data_out_en;
    logic [7:0]  o_data_out;
    logic [1:0]  o_owner;
    logic        o_timeout_flag;

    nh_lcd_bus_arbiter #(.TURNAROUND_CYCLES(TA)) dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_timeout(i_timeout),
        .i_clear_status(i_clear_status),
        .i_cmd_req(i_cmd_req), .o_cmd_gnt(o_cmd_gnt), .i_cmd_release(i_cmd_release),
        .i_pix_req(i_pix_req), .o_pix_gnt(o_pix_gnt), .i_pix_release(i_pix_release),
        .i_cmd_cmd_mode(i_cmd_cmd_mode), .i_cmd_write(i_cmd_write),
        .i_cmd_read(i_cmd_read), .i_cmd_data_out_en(i_cmd_data_out_en),
        .i_cmd_data_out(i_cmd_data_out),
        .i_pix_cmd_mode(i_pix_cmd_mode), .i_pix_write(i_pix_write),
        .i_pix_read(i_pix_read), .i_pix_data_out_en(i_pix_data_out_en),
        .i_pix_data_out(i_pix_data_out),
        .o_cmd_mode(o_cmd_mode), .o_write(o_write), .o_read(o_read),
        .o_data_out_en(o_data_out_en), .o_data_out(o_data_out),
        .o_owner(o_owner), .o_timeout_flag(o_timeout_flag)
    );

    always #5 clk = ~clk;

    // bus = {cmd_mode, write, read, data_out_en, data[7:0]}
    localparam logic [11:0] BUS_IDLE = 12'h900;

    typedef struct packed {
        logic        cg;
        logic        pg;
        logic [1:0]  own;
        logic [11:0] bus;
        logic        flag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

    // Reference model: who owns the bus, how long they have held it, how
    // many idle turnaround cycles are still owed, and who owned last.
    int          m_owner;
    int          m_held;
    int          m_ta_left;
    int          m_last;
    bit          m_flag;
    logic [11:0] m_bus;

    task automatic model_step(output exp_t e);
        bit rel, to;
        if (rst) begin
            m_owner = 0; m_held = 0; m_ta_left = 0; m_last = 2;
            m_flag = 0; m_bus = BUS_IDLE;
        end else begin
            bit set_f;
            set_f = 0;
            if (m_owner == 1)
                m_bus = {i_cmd_cmd_mode, i_cmd_write, i_cmd_read, i_cmd_data_out_en, i_cmd_data_out};
            else if (m_owner == 2)
                m_bus = {i_pix_cmd_mode, i_pix_write, i_pix_read, i_pix_data_out_en, i_pix_data_out};
            else
                m_bus = BUS_IDLE;
            if (m_owner != 0) begin
                rel = (m_owner == 1) ? i_cmd_release : i_pix_release;
                to  = (i_timeout != 0) && (longint'(m_held) + 1 >= longint'(i_timeout));
                if (rel || to) begin
                    m_owner = 0; m_ta_left = TA; set_f = to && !rel;
                end else begin
                    m_held++;
                end
            end else if (m_ta_left > 0) begin
                m_ta_left--;
            end else if (i_enable) begin
                int pick;
                pick = 0;
                if (i_cmd_req && i_pix_req) pick = (m_last == 1) ? 2 : 1;
                else if (i_cmd_req)         pick = 1;
                else if (i_pix_req)         pick = 2;
                if (pick != 0) begin
                    m_owner = pick; m_last = pick; m_held = 0;
                end
            end
            if (set_f) m_flag = 1;
            else if (i_clear_status) m_flag = 0;
        end
        e.cg   = (m_owner == 1);
        e.pg   = (m_owner == 2);
        e.own  = 2'(m_owner);
        e.bus  = m_bus;
        e.flag = m_flag;
    endtask

    // Monitor
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            logic [11:0] bus;
            e   = q.pop_front();
            bus = {o_cmd_mode, o_write, o_read, o_data_out_en, o_data_out};
            checks++;
            if ({o_cmd_gnt, o_pix_gnt, o_owner} !== {e.cg, e.pg, e.own}) begin
                errors++;
                $display("FAIL grant t=%0t got cg=%b pg=%b own=%0d exp cg=%b pg=%b own=%0d",
                         $time, o_cmd_gnt, o_pix_gnt, o_owner, e.cg, e.pg, e.own);
            end
            checks++;
            if (bus !== e.bus) begin
                errors++;
                $display("FAIL bus t=%0t got %h exp %h", $time, bus, e.bus);
            end
            checks++;
            if (o_timeout_flag !== e.flag) begin
                errors++;
                $display("FAIL flag t=%0t got %b exp %b", $time, o_timeout_flag, e.flag);
            end
            checks++;
            if (o_cmd_gnt && o_pix_gnt) begin
                errors++;
                $display("FAIL onegrant t=%0t got both grants high exp at most one", $time);
            end
        end
    end

    initial begin
        exp_t e;
        rst = 1; i_enable = 1; i_timeout = 0; i_clear_status = 0;
        i_cmd_req = 0; i_cmd_release = 0; i_pix_req = 0; i_pix_release = 0;
        {i_cmd_cmd_mode, i_cmd_write, i_cmd_read, i_cmd_data_out_en} = '0;
        {i_pix_cmd_mode, i_pix_write, i_pix_read, i_pix_data_out_en} = '0;
        i_cmd_data_out = 0; i_pix_data_out = 0;
        m_owner = 0; m_held = 0; m_ta_left = 0; m_last = 2; m_flag = 0; m_bus = BUS_IDLE;

        @(negedge clk);
        for (int ph = 0; ph < 6; ph++) begin
            int to_sel;
            to_sel = (ph == 1) ? (($urandom_range(0, 3) == 0) ? 0 : $urandom_range(3, 12)) : 0;
            for (int c = 0; c < 400; c++) begin
                rst = (c < 2) || (ph == 5 && $urandom_range(0, 39) == 0);
                {i_cmd_cmd_mode, i_cmd_write, i_cmd_read, i_cmd_data_out_en} = 4'($urandom);
                {i_pix_cmd_mode, i_pix_write, i_pix_read, i_pix_data_out_en} = 4'($urandom);
                i_cmd_data_out = 8'($urandom);
                i_pix_data_out = 8'($urandom);
                i_cmd_req      = $urandom_range(0, 1);
                i_pix_req      = $urandom_range(0, 1);
                i_cmd_release  = ($urandom_range(0, 5) == 0);
                i_pix_release  = ($urandom_range(0, 5) == 0);
                i_enable       = ($urandom_range(0, 19) != 0);
                i_clear_status = ($urandom_range(0, 19) == 0);
                case (ph)
                    1: begin
                        i_timeout     = 32'(to_sel);
                        i_cmd_release = ($urandom_range(0, 11) == 0);
                        i_pix_release = ($urandom_range(0, 11) == 0);
                    end
                    2: begin  // pix hogs the bus, timeout must reclaim it
                        i_timeout      = 10;
                        i_cmd_req      = 0;
                        i_pix_req      = 1;
                        i_pix_release  = 0;
                        i_enable       = 1;
                        i_clear_status = ($urandom_range(0, 14) == 0);
                    end
                    3: begin  // releases landing on the timeout cycle
                        i_timeout = 5;
                        i_cmd_release = (m_owner == 1) && (m_held + 1 == 5 || $urandom_range(0, 9) == 0);
                        i_pix_release = (m_owner == 2) && (m_held + 1 == 5 || $urandom_range(0, 9) == 0);
                        i_clear_status = ($urandom_range(0, 4) == 0);
                    end
                    4: begin  // enable held low with both requesting
                        i_timeout = 0;
                        if (c < 30) begin
                            i_enable = (c >= 28);
                            i_cmd_req = 1; i_pix_req = 1;
                            i_cmd_release = (c < 8); i_pix_release = (c < 8);
                        end
                    end
                    5: i_timeout = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 8);
                    default: i_timeout = 0;
                endcase
                model_step(e);
                q.push_back(e);
                @(negedge clk);
            end
        end
        rst = 0; i_cmd_req = 0; i_pix_req = 0;
        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
